ipv_expander: RTL and testbench

- Inverse of the serial IPV reduction stage: accepts a K-bit MSB-aligned thermometer vector (VOV) and re-serialises it into K IPV bits, one bit per accepted output beat.
- Ones are emitted first, then zeros. Feeding the serial stream into the reducer reproduces the original VOV.
- Sits on the transmit side of the IPV serial link.
- Valid/ready handshake on both sides, plus a one-entry pending buffer so consecutive vectors stream with no bubble.

---
 rtl/ipv_pkg.sv | 26 ++
 rtl/ipv_thermo_decode.sv | 27 ++
 rtl/ipv_expander.sv | 104 ++++++++++
 tb/tb_ipv_expander.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ipv_pkg.sv
// Shared types and helpers for the IPV serial link (expander side).
package ipv_pkg;

  localparam int K_MAX = 8;
  localparam int CNT_W = 4;

  typedef enum logic {IDLE, SHIFT} state_e;

  // Frame bookkeeping: only the popcount travels, the raw vector is not kept.
  typedef struct packed {
    logic [CNT_W-1:0] ones;
  } frame_t;

  // vec holds a k-bit code in its low bits; legal iff it equals k MSB-aligned
  // ones of length 'ones' followed by zeros.
  function automatic logic thermo_ok(input logic [K_MAX-1:0] vec,
                                     input logic [CNT_W-1:0] ones,
                                     input int unsigned k);
    logic [K_MAX-1:0] msb_al, ref_code, mask;
    msb_al   = vec << (K_MAX - k);
    ref_code = ~({K_MAX{1'b1}} >> ones);
    mask     = ~({K_MAX{1'b1}} >> k);
    return ((msb_al ^ ref_code) & mask) == '0;
  endfunction

endpackage

// File: rtl/ipv_thermo_decode.sv
// Combinational thermometer decode: popcount plus legality of the code.
module ipv_thermo_decode
  import ipv_pkg::*;
#(
  parameter int K = 4
) (
  input  logic [K-1:0]     vov,
  output logic [CNT_W-1:0] ones,
  output logic             legal
);

  logic [K_MAX-1:0] vec_ext;

  always_comb begin
    ones = '0;
    for (int i = 0; i < K; i++)
      ones = ones + {{(CNT_W-1){1'b0}}, vov[i]};
  end

  always_comb begin
    vec_ext        = '0;
    vec_ext[K-1:0] = vov;
  end

  assign legal = thermo_ok(vec_ext, ones, K);

endmodule

// File: rtl/ipv_expander.sv
// Thermometer vector -> serial IPV bits (ones first), with a one-entry
// pending buffer so back-to-back vectors stream without bubbles.
module ipv_expander
  import ipv_pkg::*;
#(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] vov_in,
  input  logic         vov_valid,
  output logic         vov_ready,
  output logic         ipv_out,
  output logic         ipv_valid,
  input  logic         ipv_ready,
  output logic         ipv_last,
  output logic         code_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(K-1);

  logic [CNT_W-1:0] dec_ones;
  logic             dec_legal;

  ipv_thermo_decode #(.K(K)) u_dec (
    .vov   (vov_in),
    .ones  (dec_ones),
    .legal (dec_legal)
  );

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  frame_t           act_q, act_n, pend_q, pend_n;
  logic             pend_full, pend_full_n;
  logic             acc, hs;

  assign vov_ready = !pend_full;
  assign acc       = vov_valid && vov_ready;
  assign hs        = ipv_valid && ipv_ready;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    act_n       = act_q;
    pend_n      = pend_q;
    pend_full_n = pend_full;
    unique case (state)
      IDLE: begin
        if (acc) begin
          state_n    = SHIFT;
          cnt_n      = '0;
          act_n.ones = dec_ones;
        end
      end
      SHIFT: begin
        if (hs && cnt == LAST) begin
          cnt_n = '0;
          // pending always wins; when it is full no new vector can be accepted
          if (pend_full) begin
            act_n       = pend_q;
            pend_full_n = 1'b0;
          end else if (acc) begin
            act_n.ones = dec_ones;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (hs) cnt_n = cnt + CNT_W'(1);
          if (acc) begin
            pend_full_n = 1'b1;
            pend_n.ones = dec_ones;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      act_q     <= '0;
      pend_q    <= '0;
      pend_full <= 1'b0;
      ipv_out   <= 1'b0;
      ipv_valid <= 1'b0;
      ipv_last  <= 1'b0;
      code_err  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      act_q     <= act_n;
      pend_q    <= pend_n;
      pend_full <= pend_full_n;
      // outputs are registered copies of the next beat
      ipv_valid <= (state_n == SHIFT);
      ipv_out   <= (state_n == SHIFT) && (cnt_n < act_n.ones);
      ipv_last  <= (state_n == SHIFT) && (cnt_n == LAST);
      code_err  <= acc && !dec_legal;
    end
  end

endmodule

// File: tb/tb_ipv_expander.sv
// Scoreboard bench for ipv_expander: K=4 directed/random plus K=8 round trip.
module tb_ipv_expander;

  logic       clk, rst_n;
  logic [3:0] vov_in;
  logic       vov_valid, vov_ready, ipv_out, ipv_valid, ipv_ready, ipv_last, code_err;

  logic [7:0] vov_in8;
  logic       vov_valid8, vov_ready8, ipv_out8, ipv_valid8, ipv_ready8, ipv_last8, code_err8;

  int n_chk = 0, n_err = 0;

  ipv_expander #(.K(4)) dut (
    .clk(clk), .rst_n(rst_n), .vov_in(vov_in), .vov_valid(vov_valid),
    .vov_ready(vov_ready), .ipv_out(ipv_out), .ipv_valid(ipv_valid),
    .ipv_ready(ipv_ready), .ipv_last(ipv_last), .code_err(code_err)
  );

  ipv_expander #(.K(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .vov_in(vov_in8), .vov_valid(vov_valid8),
    .vov_ready(vov_ready8), .ipv_out(ipv_out8), .ipv_valid(ipv_valid8),
    .ipv_ready(ipv_ready8), .ipv_last(ipv_last8), .code_err(code_err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // legal iff no 1 appears below a 0 when scanning from the MSB
  function automatic bit legal4(input logic [3:0] v);
    bit seen0 = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) seen0 = 1'b1;
      else if (seen0) return 1'b0;
    end
    return 1'b1;
  endfunction

  typedef struct packed { logic b; logic last; } beat_t;
  beat_t      q4[$];
  logic [7:0] q8[$];
  logic       err_exp;
  logic       stall_prev;
  logic [2:0] held;
  logic [7:0] sr8;
  int         nb8;

  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete(); q8.delete();
      err_exp = 1'b0; stall_prev = 1'b0; sr8 = '0; nb8 = 0;
    end else begin
      chk("code_err", 32'(code_err), 32'(err_exp));
      if (stall_prev) chk("hold", 32'({ipv_valid, ipv_out, ipv_last}), 32'(held));
      if (ipv_valid && ipv_ready) begin
        if (q4.size() == 0) chk("spurious_bit", 32'(1), 32'(0));
        else begin
          beat_t e;
          e = q4.pop_front();
          chk("bit", 32'(ipv_out), 32'(e.b));
          chk("last", 32'(ipv_last), 32'(e.last));
        end
      end
      stall_prev = ipv_valid && !ipv_ready;
      held       = {ipv_valid, ipv_out, ipv_last};
      err_exp    = vov_valid && vov_ready && !legal4(vov_in);
      if (vov_valid && vov_ready) begin
        int ones;
        ones = $countones(vov_in);
        for (int i = 0; i < 4; i++) q4.push_back('{b: (i < ones), last: (i == 3)});
      end
      // K=8: tiny reducer model shifting bits in MSB-first
      if (ipv_valid8 && ipv_ready8) begin
        sr8 = {sr8[6:0], ipv_out8};
        nb8++;
        if (ipv_last8) begin
          chk("len8", 32'(nb8), 32'(8));
          if (q8.size() == 0) chk("spurious8", 32'(1), 32'(0));
          else chk("roundtrip8", 32'(sr8), 32'(q8.pop_front()));
          nb8 = 0;
        end
      end
      if (vov_valid8 && vov_ready8) q8.push_back(vov_in8);
    end
  end

  task automatic send(input logic [3:0] v);
    int n = 0;
    vov_in = v; vov_valid = 1'b1;
    @(negedge clk);
    while (!vov_ready && n < 200) begin @(negedge clk); n++; end
    if (!vov_ready) chk("accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    vov_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] v);
    int n = 0;
    vov_in8 = v; vov_valid8 = 1'b1;
    @(negedge clk);
    while (!vov_ready8 && n < 200) begin @(negedge clk); n++; end
    if (!vov_ready8) chk("accept8_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    vov_valid8 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; vov_in = '0; vov_valid = 1'b0; ipv_ready = 1'b1;
    vov_in8 = '0; vov_valid8 = 1'b0; ipv_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'({ipv_out, ipv_valid, ipv_last, code_err}), 32'(0));
    chk("rst_ready", 32'(vov_ready), 32'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single frame, first bit on the cycle after accept
    send(4'b1100);
    chk("latency_valid", 32'(ipv_valid), 32'(1));
    chk("latency_bit", 32'(ipv_out), 32'(1));
    repeat (6) @(posedge clk);
    #1 chk("idle_after", 32'(ipv_valid), 32'(0));

    // back-to-back frames with no bubble
    fork
      begin send(4'b1110); send(4'b0000); send(4'b1111); end
      begin
        int n = 0;
        @(negedge clk);
        while (!ipv_valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 12; i++) begin
          chk("no_bubble", 32'(ipv_valid), 32'(1));
          @(negedge clk);
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // stall during 1000, second vector fills pending
    ipv_ready = 1'b0;
    send(4'b1000);
    send(4'b1100);
    chk("pend_full_ready", 32'(vov_ready), 32'(0));
    repeat (2) @(posedge clk);
    #1 chk("stall_ready", 32'(vov_ready), 32'(0));
    ipv_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("pend_drained", 32'(vov_ready), 32'(1));
    repeat (6) @(posedge clk);
    #1;

    // illegal code serialised by popcount
    send(4'b0101);
    repeat (6) @(posedge clk);
    #1;

    // async reset mid-frame with a pending vector
    send(4'b1111);
    send(4'b1000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'({ipv_out, ipv_valid, ipv_last, code_err}), 32'(0));
    chk("async_rst_ready", 32'(vov_ready), 32'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_residual", 32'(ipv_valid), 32'(0));
    end
    chk("post_rst_ready", 32'(vov_ready), 32'(1));
    @(posedge clk); #1;

    // random vectors under random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          @(posedge clk); #1;
          ipv_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 25; i++) send(4'($urandom_range(0, 15)));
      end
    join
    ipv_ready = 1'b1;

    // K=8 round trip over all legal codes
    for (int o = 0; o <= 8; o++) begin
      logic [7:0] all1;
      all1 = 8'hFF;
      send8(~(all1 >> o));
    end
    repeat (30) @(posedge clk);
    #1;
    chk("drain4", 32'(q4.size()), 32'(0));
    chk("drain8", 32'(q8.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
